// File: rtl/spike_decoder_if.sv
// spike_decoder_if: sample output port of the spike decoder.
// The decoder drives sample/count/valid/overrun; the consumer drives ready.
interface spike_decoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      sample_o;
    logic [CNT_W-1:0] up_cnt_o;
    logic [CNT_W-1:0] dn_cnt_o;
    logic             valid_o;
    logic             ready_i;
    logic             overrun_o;

    modport master (
        output sample_o,
        output up_cnt_o,
        output dn_cnt_o,
        output valid_o,
        output overrun_o,
        input  ready_i
    );

    modport slave (
        input  sample_o,
        input  up_cnt_o,
        input  dn_cnt_o,
        input  valid_o,
        input  overrun_o,
        output ready_i
    );
endinterface

// File: rtl/spike_decoder.sv
// spike_decoder: rebuilds an amplitude trace from a delta-modulated spike
// train and emits one sample plus up/down event counts per CLK_DIV window.
// Optional feature macro: SPIKE_DECODER_SAT_EN (saturating accumulator);
// without it the accumulator wraps modulo 2^32.
module spike_decoder #(
    parameter int unsigned CLK_DIV      = 1200000,
    parameter logic [31:0] DEFAULT_INIT = 32'd40,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   spike_up_i,
    input  logic                   spike_dn_i,
    input  logic [31:0]            delta_i,
    input  logic                   load_i,
    input  logic [31:0]            load_val_i,
    spike_decoder_if.master        out_if
);

    localparam int unsigned ACC_W = 32;
    localparam int unsigned WIN_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_DIV - 1);

    // Edge detection state
    logic             spike_up_q;
    logic             spike_dn_q;
    logic             up_ev;
    logic             dn_ev;

    // Accumulator and window state
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic             win_last;

    // Per-window spike counters
    logic [CNT_W-1:0] up_cnt_q;
    logic [CNT_W-1:0] up_cnt_d;
    logic [CNT_W-1:0] dn_cnt_q;
    logic [CNT_W-1:0] dn_cnt_d;

    // Output register
    logic [ACC_W-1:0] sample_q;
    logic [ACC_W-1:0] sample_d;
    logic [CNT_W-1:0] out_up_q;
    logic [CNT_W-1:0] out_up_d;
    logic [CNT_W-1:0] out_dn_q;
    logic [CNT_W-1:0] out_dn_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             xfer;

    // A level held high produces a single event on its rising edge
    always_comb begin
        up_ev = spike_up_i & ~spike_up_q;
        dn_ev = spike_dn_i & ~spike_dn_q;
    end

    // Accumulator next value: load beats events, opposing events cancel
`ifdef SPIKE_DECODER_SAT_EN
    logic [ACC_W:0]   acc_sum;
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, delta_i};
        acc_d   = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (up_ev && dn_ev) begin
            acc_d = acc_q;
        end else if (up_ev) begin
            acc_d = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        end else if (dn_ev) begin
            acc_d = (acc_q < delta_i) ? ACC_W'(0) : (acc_q - delta_i);
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (up_ev && dn_ev) begin
            acc_d = acc_q;
        end else if (up_ev) begin
            acc_d = acc_q + delta_i;
        end else if (dn_ev) begin
            acc_d = acc_q - delta_i;
        end
    end
`endif

    // Window counter and saturating spike counters
    always_comb begin
        win_last = (win_q == WIN_LAST);
        win_d    = win_last ? WIN_W'(0) : (win_q + WIN_W'(1));

        up_cnt_d = up_cnt_q;
        if (up_ev && (up_cnt_q != {CNT_W{1'b1}})) begin
            up_cnt_d = up_cnt_q + CNT_W'(1);
        end

        dn_cnt_d = dn_cnt_q;
        if (dn_ev && (dn_cnt_q != {CNT_W{1'b1}})) begin
            dn_cnt_d = dn_cnt_q + CNT_W'(1);
        end
    end

    // Output capture at window end and valid/ready bookkeeping
    always_comb begin
        sample_d  = sample_q;
        out_up_d  = out_up_q;
        out_dn_d  = out_dn_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        xfer      = valid_q & out_if.ready_i;

        if (win_last) begin
            sample_d = acc_d;
            out_up_d = up_cnt_d;
            out_dn_d = dn_cnt_d;
            valid_d  = 1'b1;
            if (valid_q && !out_if.ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spike_up_q <= 1'b0;
            spike_dn_q <= 1'b0;
            acc_q      <= DEFAULT_INIT;
            win_q      <= WIN_W'(0);
            up_cnt_q   <= CNT_W'(0);
            dn_cnt_q   <= CNT_W'(0);
            sample_q   <= DEFAULT_INIT;
            out_up_q   <= CNT_W'(0);
            out_dn_q   <= CNT_W'(0);
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            spike_up_q <= spike_up_i;
            spike_dn_q <= spike_dn_i;
            acc_q      <= acc_d;
            win_q      <= win_d;
            up_cnt_q   <= win_last ? CNT_W'(0) : up_cnt_d;
            dn_cnt_q   <= win_last ? CNT_W'(0) : dn_cnt_d;
            sample_q   <= sample_d;
            out_up_q   <= out_up_d;
            out_dn_q   <= out_dn_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Drive the output port from the registers
    always_comb begin
        out_if.sample_o  = sample_q;
        out_if.up_cnt_o  = out_up_q;
        out_if.dn_cnt_o  = out_dn_q;
        out_if.valid_o   = valid_q;
        out_if.overrun_o = overrun_q;
    end

endmodule

// File: tb/tb_spike_decoder.sv
// tb_spike_decoder: directed, table-driven bench for spike_decoder (CLK_DIV=8).
module tb_spike_decoder;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned CNT_W   = 16;
`ifdef SPIKE_DECODER_SAT_EN
    localparam logic [31:0] UF_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] UF_EXP = 32'hFFFF_FFFE;
`endif

    typedef struct {
        logic        rst;
        logic        up;
        logic        dn;
        logic        ld;
        logic [31:0] lv;
        logic [31:0] dl;
        logic        rdy;
        logic        ev;
        logic [31:0] es;
        logic [31:0] eu;
        logic [31:0] ed;
        logic        eo;
        logic        cd;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        spike_up;
    logic        spike_dn;
    logic [31:0] delta;
    logic        load;
    logic [31:0] load_val;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    spike_decoder_if #(.CNT_W(CNT_W)) out_if();

    spike_decoder #(
        .CLK_DIV      (CLK_DIV),
        .DEFAULT_INIT (32'd40),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .spike_up_i (spike_up),
        .spike_dn_i (spike_dn),
        .delta_i    (delta),
        .load_i     (load),
        .load_val_i (load_val),
        .out_if     (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic u, input logic d, input logic l,
                       input logic [31:0] lv, input logic [31:0] dl, input logic rdy,
                       input logic ev, input logic [31:0] es, input logic [31:0] eu,
                       input logic [31:0] ed, input logic eo, input logic cd);
        vec_t v;
        v.rst = r; v.up = u; v.dn = d; v.ld = l; v.lv = lv; v.dl = dl; v.rdy = rdy;
        v.ev = ev; v.es = es; v.eu = eu; v.ed = ed; v.eo = eo; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [31:0] es,
                             input logic [31:0] eu, input logic [31:0] ed, input logic eo,
                             input logic cd);
        chk({tag, ".valid"}, 32'(out_if.valid_o), 32'(ev));
        chk({tag, ".overrun"}, 32'(out_if.overrun_o), 32'(eo));
        if (cd) begin
            chk({tag, ".sample"}, out_if.sample_o, es);
            chk({tag, ".up_cnt"}, 32'(out_if.up_cnt_o), eu);
            chk({tag, ".dn_cnt"}, 32'(out_if.dn_cnt_o), ed);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; spike_up = 1'b0; spike_dn = 1'b0; delta = 32'd0;
        load = 1'b0; load_val = 32'd0; out_if.ready_i = 1'b0;

        // Basic reconstruction: 40 +5 +5 +5 -5 = 50
        add(1,0,0,0,0,5,1, 0,40,0,0,0,1);
        add(0,1,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,1,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,1,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,1,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 1,50,3,1,0,1);
        add(0,0,0,0,0,5,1, 0,50,3,1,0,0);
        // Held level counts once; simultaneous up+down cancel in the accumulator
        add(1,0,0,0,0,5,1, 0,40,0,0,0,1);
        for (int i = 0; i < 5; i++) add(0,1,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,1,1,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 1,45,2,1,0,1);
        add(0,0,0,0,0,5,1, 0,45,2,1,0,0);
        // Load priority over an up event, then backpressure for two windows
        add(1,0,0,0,0,5,1, 0,40,0,0,0,1);
        add(0,1,0,1,100,5,1, 0,40,0,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,0,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,1,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,0,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,1,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,0,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,0,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,0,0,0,0,5,0, 1,100,1,0,0,1);
        add(0,0,0,0,0,5,0, 1,110,2,0,1,1);
        add(0,0,0,0,0,5,1, 0,110,2,0,1,0);
        add(0,0,0,0,0,5,1, 0,110,2,0,1,0);
        // Underflow: 3 - 5
        add(1,0,0,0,0,5,1, 0,40,0,0,0,1);
        add(0,0,0,1,3,5,1, 0,40,0,0,0,0);
        add(0,0,1,0,0,5,1, 0,40,0,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,0,5,1, 0,40,0,0,0,0);
        add(0,0,0,0,0,5,1, 1,UF_EXP,0,1,0,1);
        add(0,0,0,0,0,5,1, 0,UF_EXP,0,1,0,0);

        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            spike_up       = vecs[i].up;
            spike_dn       = vecs[i].dn;
            load           = vecs[i].ld;
            load_val       = vecs[i].lv;
            delta          = vecs[i].dl;
            out_if.ready_i = vecs[i].rdy;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].eu,
                      vecs[i].ed, vecs[i].eo, vecs[i].cd);
        end

        // Reset mid-window with a pending sample and a partial window
        rst = 1'b1; spike_up = 1'b0; spike_dn = 1'b0; load = 1'b0;
        delta = 32'd5; out_if.ready_i = 1'b0;
        tick();
        rst = 1'b0;
        spike_up = 1'b1; tick();
        spike_up = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_out("pend", 1'b1, 32'd45, 32'd1, 32'd0, 1'b0, 1'b1);
        spike_up = 1'b1; tick();
        spike_up = 1'b0; tick();
        spike_up = 1'b1; tick();
        spike_up = 1'b0; tick();
        tick();
        rst = 1'b1; tick();
        check_out("midrst", 1'b0, 32'd40, 32'd0, 32'd0, 1'b0, 1'b1);
        rst = 1'b0;
        spike_up = 1'b1; tick();
        spike_up = 1'b0;
        n = 1;
        while (out_if.valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_latency", 32'(n), 32'(CLK_DIV));
        check_out("postrst", 1'b1, 32'd45, 32'd1, 32'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_decoder.md
# spike_decoder

Reconstructs an ECG-like amplitude trace from a delta-modulated spike train. Each up-spike adds `delta_i` to an internal accumulator and each down-spike subtracts it. At the end of each `CLK_DIV`-cycle window the block emits one reconstructed sample, with that window's up and down spike counts, over a valid/ready output port. It sits downstream of the spike encoder and the SNN core, and provides the loop-back and reconstruction path for signal-fidelity checks.

## Interface
- `CLK_DIV`, default 1200000: sample window length in `clk_i` cycles; must be ≥2.
- `DEFAULT_INIT`, default 40: accumulator value after reset.
- `CNT_W`, default 16: width of the per-window spike counters.
- `clk_i` input, 1 bit: the single clock.
- `rst_i` input, 1 bit: reset. It is synchronous and active-high.
- `spike_up_i` input, 1 bit: up-spike level. It may stay high for several cycles.
- `spike_dn_i` input, 1 bit: down-spike level. It may stay high for several cycles.
- `delta_i` input, 32 bits: unsigned step size, sampled on each event cycle.
- `load_i` input, 1 bit: one-cycle strobe that overwrites the accumulator.
- `load_val_i` input, 32 bits: value loaded when `load_i` is high.
- `sample_o` output, 32 bits: reconstructed sample.
- `up_cnt_o` output, `CNT_W` bits: up events in the reported window.
- `dn_cnt_o` output, `CNT_W` bits: down events in the reported window.
- `valid_o` output, 1 bit: output holds an unconsumed sample.
- `ready_i` input, 1 bit: consumer accepts the sample.
- `overrun_o` output, 1 bit: sticky flag; a sample was overwritten before it was accepted.

## Operation
- **Event detection.** The block registers `spike_up_i` and `spike_dn_i` (reset to 0).
  - An up event is `spike_up_i & ~spike_up_q`; a down event is defined the same way on `spike_dn_i`.
  - A level held high counts as one event.
- **Accumulator update.** Priority, highest first:
  1. `load_i`: the accumulator takes `load_val_i`. Events in the same cycle are still counted but do not change the accumulator.
  2. Up and down events together: the accumulator is unchanged and both are counted.
  3. Up event only: `acc + delta_i`.
  4. Down event only: `acc - delta_i`.
- **Arithmetic.** All accumulator arithmetic is unsigned 32-bit. Overflow handling is set by the macro in Configuration.
- **Window counter.** Counts 0..`CLK_DIV-1` and wraps.
  - It is unaffected by `load_i`.
  - In the terminal cycle (`cnt == CLK_DIV-1`), the output register captures the accumulator's next value and the counters' next values, so events in the terminal cycle belong to the closing window.
  - The window counters then restart at 0.
- **Spike counters.** Saturate at all-ones; they do not wrap.
- **Output handshake.**
  - A sample is transferred when `valid_o && ready_i`; `valid_o` clears on the next edge unless a new capture occurs in the same cycle.
  - While `valid_o` is high, `sample_o`, `up_cnt_o` and `dn_cnt_o` hold stable until transfer or until a new capture.
  - If a capture occurs while `valid_o` is high and `ready_i` is low: the new sample overwrites the old one, `valid_o` stays high, and `overrun_o` is set.
  - If a capture occurs in the same cycle as a transfer: the new sample is loaded, `valid_o` stays high, and no overrun is flagged.
- **Clearing overrun.** `overrun_o` clears only on reset.

## Timing
- **Reset values.**
  - Accumulator = `DEFAULT_INIT`; window counter = 0; spike counters = 0.
  - `sample_o` = `DEFAULT_INIT`; `up_cnt_o` = `dn_cnt_o` = 0.
  - `valid_o` = 0; `overrun_o` = 0.
- **Reset mid-window.** Discards any partial window and any pending sample.
- **Event latency.** A spike rising edge presented at cycle n updates the accumulator visibly at cycle n+1.
- **Sample latency.** `valid_o` rises in the cycle after the terminal cycle, so the first sample after reset appears at cycle `CLK_DIV`.
- **Throughput.** One sample per window. `ready_i` is not required to be combinationally tied to `valid_o`.

## Configuration
- **`SPIKE_DECODER_SAT_EN` defined:**
  - The accumulator saturates: an addition that overflows clamps to 32'hFFFF_FFFF.
  - A subtraction that would go below 0 clamps to 0.
- **`SPIKE_DECODER_SAT_EN` undefined:** the accumulator wraps modulo 2^32.
- **Either way:** spike counters always saturate, and `load_i` is unaffected.

## Test plan
All scenarios use `CLK_DIV`=8.
- **Basic reconstruction.** Reset; `delta_i`=5; three separate 1-cycle up pulses and one down pulse in the first window, `ready_i`=1.
  - Required: `sample_o`=50, `up_cnt_o`=3, `dn_cnt_o`=1.
  - Required: `valid_o` high for exactly one cycle at cycle 8.
- **Held level and simultaneous spikes.** Hold `spike_up_i` high for 5 cycles, then pulse up and down in the same cycle.
  - Required: `sample_o`=`DEFAULT_INIT`+`delta_i`.
  - Required: `up_cnt_o`=2, `dn_cnt_o`=1.
- **Load priority.** `load_i`=1 with `load_val_i`=100 in the same cycle as an up event, `delta_i`=5, then no other events.
  - Required: `sample_o`=100, `up_cnt_o`=1.
- **Backpressure.** `ready_i`=0 for 2 windows.
  - Required: `valid_o` stays high and `sample_o` shows the second window's value.
  - Required: `overrun_o`=1 from cycle 16.
  - Then `ready_i`=1: `valid_o` drops the next cycle and `overrun_o` stays 1.
- **Underflow.** Load 3, then `delta_i`=5 with one down event.
  - With `SPIKE_DECODER_SAT_EN`: `sample_o`=0.
  - Without it: `sample_o`=32'hFFFF_FFFE.
- **Reset mid-window.** Assert `rst_i` at cycle 5 of a window containing events.
  - Required: all outputs return to their reset values, and the next sample appears exactly `CLK_DIV` cycles after reset is released, with counts covering only post-reset events.
